// File: rtl/imc_wb_pkg.sv
// Shared constants and types for the IMC Wishbone slave responder.
// Holds the decoded word offsets of the buffer window, the FSM state
// encoding and the bit positions of the one-hot target select.
package imc_wb_pkg;

  // Word offsets inside the IMC buffer window
  localparam logic [7:0] ADR_IB = 8'h31;
  localparam logic [7:0] ADR_WB = 8'h32;
  localparam logic [7:0] ADR_OB = 8'h33;
  localparam logic [7:0] ADR_IM = 8'h40;
  localparam logic [7:0] ADR_SA = 8'h41;

  // FSM state encoding
  localparam logic [2:0] ST_IDLE    = 3'd0;
  localparam logic [2:0] ST_WR      = 3'd1;
  localparam logic [2:0] ST_RD_ISS  = 3'd2;
  localparam logic [2:0] ST_RD_WAIT = 3'd3;
  localparam logic [2:0] ST_ACK     = 3'd4;

  typedef enum logic [2:0] {
    IDLE    = ST_IDLE,
    WR      = ST_WR,
    RD_ISS  = ST_RD_ISS,
    RD_WAIT = ST_RD_WAIT,
    ACK     = ST_ACK
  } state_t;

  // Bit positions of the one-hot target select
  localparam int TGT_IB  = 0;
  localparam int TGT_WB  = 1;
  localparam int TGT_OB  = 2;
  localparam int TGT_IM  = 3;
  localparam int TGT_SA  = 4;
  localparam int NUM_TGT = 5;

  typedef logic [NUM_TGT-1:0] tgt_sel_t;

endpackage

// File: rtl/imc_wb_slave_resp_if.sv
// Wishbone classic slave-side bus bundle for the IMC buffer window.
// The error output only exists when IMC_WB_ERR_EN is defined.
interface imc_wb_slave_resp_if;

  logic        wbs_cyc_i;
  logic        wbs_stb_i;
  logic        wbs_we_i;
  logic [31:0] wbs_adr_i;
  logic [31:0] wbs_dat_i;
  logic [31:0] wbs_dat_o;
  logic        wbs_ack_o;
`ifdef IMC_WB_ERR_EN
  logic        wbs_err_o;
`endif

  modport slave (
    input  wbs_cyc_i,
    input  wbs_stb_i,
    input  wbs_we_i,
    input  wbs_adr_i,
    input  wbs_dat_i,
    output wbs_dat_o,
    output wbs_ack_o
`ifdef IMC_WB_ERR_EN
    ,
    output wbs_err_o
`endif
  );

  modport master (
    output wbs_cyc_i,
    output wbs_stb_i,
    output wbs_we_i,
    output wbs_adr_i,
    output wbs_dat_i,
    input  wbs_dat_o,
    input  wbs_ack_o
`ifdef IMC_WB_ERR_EN
    ,
    input  wbs_err_o
`endif
  );

endinterface

// File: rtl/imc_wb_addr_dec.sv
// Combinational offset decoder for the IMC buffer window.
// Maps a word offset plus direction onto a one-hot target select and
// flags whether the access is legal (mapped and in the right direction).
module imc_wb_addr_dec
  import imc_wb_pkg::*;
#(
  parameter int WIDTH_ADD = 8
) (
  input  logic [WIDTH_ADD-1:0] offset,
  input  logic                 we,
  output tgt_sel_t             sel,
  output logic                 legal
);

  // Write-only targets: IB, WB, IM. Read-only targets: OB, SA.
  always_comb begin
    sel   = '0;
    legal = 1'b0;
    case (offset)
      WIDTH_ADD'(ADR_IB): if (we)  begin sel[TGT_IB] = 1'b1; legal = 1'b1; end
      WIDTH_ADD'(ADR_WB): if (we)  begin sel[TGT_WB] = 1'b1; legal = 1'b1; end
      WIDTH_ADD'(ADR_IM): if (we)  begin sel[TGT_IM] = 1'b1; legal = 1'b1; end
      WIDTH_ADD'(ADR_OB): if (!we) begin sel[TGT_OB] = 1'b1; legal = 1'b1; end
      WIDTH_ADD'(ADR_SA): if (!we) begin sel[TGT_SA] = 1'b1; legal = 1'b1; end
      default: begin
        sel   = '0;
        legal = 1'b0;
      end
    endcase
  end

endmodule

// File: rtl/imc_wb_slave_resp.sv
// Wishbone classic slave responder for the IMC buffer window.
// Decodes accesses inside the BASE_ADR window, issues one-cycle strobes
// to the buffers, waits RD_LAT cycles for read data and returns a
// registered acknowledge.
// Optional feature: define IMC_WB_ERR_EN to add wbs_err_o, which then
// replaces the acknowledge for illegal accesses.
module imc_wb_slave_resp
  import imc_wb_pkg::*;
#(
  parameter int          WIDTH_ADD = 8,
  parameter logic [31:0] BASE_ADR  = 32'h3000_0000,
  parameter int          RD_LAT    = 1
) (
  input  logic                wb_clk_i,
  input  logic                wb_rst_i,
  imc_wb_slave_resp_if.slave  wbs,
  output logic [31:0]         buf_wr_data,
  output logic                ib_wr_en,
  output logic                wb_wr_en,
  output logic                im_wr_en,
  output logic                ob_rd_en,
  output logic                sa_rd_en,
  input  logic [31:0]         ob_rd_data,
  input  logic [31:0]         sa_rd_data
);

  localparam logic [3:0] LAT_INIT = 4'(RD_LAT - 1);

  logic [WIDTH_ADD-1:0] offset;
  logic                 base_hit;
  logic                 req;
  tgt_sel_t             sel;
  logic                 legal;
  logic                 unused_adr_bits;

  state_t               state;
  logic [3:0]           lat_cnt;
  logic                 ack_q;
  logic                 rd_ack_q;
  logic                 rd_from_sa;
`ifdef IMC_WB_ERR_EN
  logic                 err_q;
`endif

  assign offset          = wbs.wbs_adr_i[WIDTH_ADD+1:2];
  assign base_hit        = (wbs.wbs_adr_i[31:WIDTH_ADD+2] == BASE_ADR[31:WIDTH_ADD+2]);
  assign req             = wbs.wbs_cyc_i & wbs.wbs_stb_i & base_hit;
  assign unused_adr_bits = ^wbs.wbs_adr_i[1:0];

  imc_wb_addr_dec #(
    .WIDTH_ADD (WIDTH_ADD)
  ) u_addr_dec (
    .offset (offset),
    .we     (wbs.wbs_we_i),
    .sel    (sel),
    .legal  (legal)
  );

  // Read data is only driven during a read acknowledge; the source is
  // selected by the strobe that started the read.
  assign wbs.wbs_dat_o = rd_ack_q ? (rd_from_sa ? sa_rd_data : ob_rd_data) : 32'd0;
  assign wbs.wbs_ack_o = ack_q;
`ifdef IMC_WB_ERR_EN
  assign wbs.wbs_err_o = err_q;
`endif

  // Transaction FSM: strobes, ack and write data are one-cycle registered
  // pulses cleared by default every cycle and set only on state entry.
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      state       <= IDLE;
      lat_cnt     <= 4'd0;
      ack_q       <= 1'b0;
      rd_ack_q    <= 1'b0;
      rd_from_sa  <= 1'b0;
      buf_wr_data <= 32'd0;
      ib_wr_en    <= 1'b0;
      wb_wr_en    <= 1'b0;
      im_wr_en    <= 1'b0;
      ob_rd_en    <= 1'b0;
      sa_rd_en    <= 1'b0;
`ifdef IMC_WB_ERR_EN
      err_q       <= 1'b0;
`endif
    end else begin
      ack_q       <= 1'b0;
      rd_ack_q    <= 1'b0;
      buf_wr_data <= 32'd0;
      ib_wr_en    <= 1'b0;
      wb_wr_en    <= 1'b0;
      im_wr_en    <= 1'b0;
      ob_rd_en    <= 1'b0;
      sa_rd_en    <= 1'b0;
`ifdef IMC_WB_ERR_EN
      err_q       <= 1'b0;
`endif
      case (state)
        IDLE: begin
          if (req) begin
            if (legal && wbs.wbs_we_i) begin
              state       <= WR;
              ib_wr_en    <= sel[TGT_IB];
              wb_wr_en    <= sel[TGT_WB];
              im_wr_en    <= sel[TGT_IM];
              buf_wr_data <= wbs.wbs_dat_i;
              ack_q       <= 1'b1;
            end else if (legal) begin
              state      <= RD_ISS;
              ob_rd_en   <= sel[TGT_OB];
              sa_rd_en   <= sel[TGT_SA];
              rd_from_sa <= sel[TGT_SA];
            end else begin
              state <= ACK;
`ifdef IMC_WB_ERR_EN
              err_q <= 1'b1;
`else
              ack_q <= 1'b1;
`endif
            end
          end
        end
        WR: begin
          state <= IDLE;
        end
        RD_ISS: begin
          if (!wbs.wbs_cyc_i) begin
            state <= IDLE;
          end else if (RD_LAT <= 1) begin
            state    <= ACK;
            ack_q    <= 1'b1;
            rd_ack_q <= 1'b1;
          end else begin
            state   <= RD_WAIT;
            lat_cnt <= LAT_INIT;
          end
        end
        RD_WAIT: begin
          if (!wbs.wbs_cyc_i) begin
            state   <= IDLE;
            lat_cnt <= 4'd0;
          end else if (lat_cnt <= 4'd1) begin
            state    <= ACK;
            lat_cnt  <= 4'd0;
            ack_q    <= 1'b1;
            rd_ack_q <= 1'b1;
          end else begin
            lat_cnt <= lat_cnt - 4'd1;
          end
        end
        ACK: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_imc_wb_slave_resp.sv
// Self-checking bench for imc_wb_slave_resp: directed scenarios followed
// by randomized accesses, each compared cycle by cycle against a
// table-driven model of the expected bus and strobe behaviour.
module tb_imc_wb_slave_resp;

  localparam int          RD_LAT = 3;
  localparam logic [31:0] BASE   = 32'h3000_0000;
  localparam int          WIN    = RD_LAT + 3;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] buf_wr_data;
  logic        ib_wr_en, wb_wr_en, im_wr_en, ob_rd_en, sa_rd_en;
  logic [31:0] ob_rd_data, sa_rd_data;
  logic        err_obs;

  int total = 0;
  int bad   = 0;

  imc_wb_slave_resp_if bus ();

  imc_wb_slave_resp #(
    .WIDTH_ADD (8),
    .BASE_ADR  (BASE),
    .RD_LAT    (RD_LAT)
  ) dut (
    .wb_clk_i    (clk),
    .wb_rst_i    (rst),
    .wbs         (bus),
    .buf_wr_data (buf_wr_data),
    .ib_wr_en    (ib_wr_en),
    .wb_wr_en    (wb_wr_en),
    .im_wr_en    (im_wr_en),
    .ob_rd_en    (ob_rd_en),
    .sa_rd_en    (sa_rd_en),
    .ob_rd_data  (ob_rd_data),
    .sa_rd_data  (sa_rd_data)
  );

`ifdef IMC_WB_ERR_EN
  assign err_obs = bus.wbs_err_o;
`else
  assign err_obs = 1'b0;
`endif

  always #5 clk = ~clk;

  // One comparison: count it, report a mismatch
  task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("[TB] FAIL %s got=%h want=%h", tag, got, want);
    end
  endtask

  // Observed control word: {ib,wb,im,ob,sa,ack,err}
  function automatic logic [63:0] obs_ctl();
    return {57'd0, ib_wr_en, wb_wr_en, im_wr_en, ob_rd_en, sa_rd_en, bus.wbs_ack_o, err_obs};
  endfunction

  function automatic logic [63:0] obs_dat();
    return {bus.wbs_dat_o, buf_wr_data};
  endfunction

  // Drive one access (called at a negedge while the DUT is idle).
  // mode 0: normal, 1: back-to-back (request held, return in next idle cycle),
  // 2: drop cyc after the strobe cycle, 3: reset during the wait cycles.
  task automatic applyStimulus(input logic we, input logic [31:0] adr, input logic [31:0] dat,
                               input logic [31:0] src, input int mode_in, input string name);
    logic        hit;
    logic [7:0]  off;
    int          tgt;
    int          ack_at;
    int          last;
    int          mode;
    logic [63:0] ectl, edat;
    hit  = (adr[31:10] == BASE[31:10]);
    off  = adr[9:2];
    mode = mode_in;
    // ctl bit positions: ib=6 wb=5 im=4 ob=3 sa=2
    tgt = -1;
    if (we) begin
      if (off == 8'h31) tgt = 6;
      if (off == 8'h32) tgt = 5;
      if (off == 8'h40) tgt = 4;
    end else begin
      if (off == 8'h33) tgt = 3;
      if (off == 8'h41) tgt = 2;
    end
    if (!hit)                   ack_at = 0;
    else if (tgt >= 0 && !we)   ack_at = 1 + RD_LAT;
    else                        ack_at = 1;
    if (mode == 2 || mode == 3) ack_at = 0;
    if (mode == 1 && ack_at == 0) mode = 0;
    last = (mode == 1) ? ack_at : WIN;

    bus.wbs_cyc_i = 1'b1;
    bus.wbs_stb_i = 1'b1;
    bus.wbs_we_i  = we;
    bus.wbs_adr_i = adr;
    bus.wbs_dat_i = dat;

    for (int k = 1; k <= last; k++) begin
      @(posedge clk);
      #1;
      ob_rd_data = (k == 1 + RD_LAT) ? src : ~src;
      sa_rd_data = (k == 1 + RD_LAT) ? src : ~src;
      @(negedge clk);
      ectl = '0;
      edat = '0;
      if (hit && k == 1 && tgt >= 0) ectl[tgt] = 1'b1;
      if (hit && k == 1 && tgt >= 0 && we) edat[31:0] = dat;
      if (k == ack_at) begin
        if (tgt < 0) begin
`ifdef IMC_WB_ERR_EN
          ectl[0] = 1'b1;
`else
          ectl[1] = 1'b1;
`endif
        end else begin
          ectl[1] = 1'b1;
          if (!we) edat[63:32] = src;
        end
      end
      checkOutput($sformatf("%s k%0d ctl", name, k), obs_ctl(), ectl);
      checkOutput($sformatf("%s k%0d dat", name, k), obs_dat(), edat);
      if (k == ack_at && mode != 1) begin
        bus.wbs_cyc_i = 1'b0;
        bus.wbs_stb_i = 1'b0;
      end
      if (mode == 2 && k == 1) begin
        bus.wbs_cyc_i = 1'b0;
        bus.wbs_stb_i = 1'b0;
      end
      if (mode == 3 && k == 2) begin
        rst           = 1'b1;
        bus.wbs_cyc_i = 1'b0;
        bus.wbs_stb_i = 1'b0;
      end
      if (mode == 3 && k == 3) rst = 1'b0;
    end

    if (mode == 1) begin
      @(negedge clk);
    end else begin
      bus.wbs_cyc_i = 1'b0;
      bus.wbs_stb_i = 1'b0;
      @(negedge clk);
    end
  endtask

  logic [7:0] off_tbl [8] = '{8'h31, 8'h32, 8'h33, 8'h40, 8'h41, 8'h00, 8'h3F, 8'hFF};

  initial begin
    logic [31:0] a;
    logic        w;
    int          m;
    rst           = 1'b1;
    bus.wbs_cyc_i = 1'b0;
    bus.wbs_stb_i = 1'b0;
    bus.wbs_we_i  = 1'b0;
    bus.wbs_adr_i = 32'd0;
    bus.wbs_dat_i = 32'd0;
    ob_rd_data    = 32'd0;
    sa_rd_data    = 32'd0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checkOutput("reset ctl", obs_ctl(), 64'd0);
    checkOutput("reset dat", obs_dat(), 64'd0);
    rst = 1'b0;
    @(negedge clk);

    $display("[TB] directed accesses");
    applyStimulus(1'b1, 32'h3000_00C4, 32'hDEADBEEF, 32'd0,          0, "wr_ib");
    applyStimulus(1'b0, 32'h3000_00CC, 32'd0,        32'h1234_5678,  0, "rd_ob");
    applyStimulus(1'b0, 32'h3000_0104, 32'd0,        32'hA5A5_0F0F,  1, "b2b_rd_sa");
    applyStimulus(1'b1, 32'h3000_0100, 32'hC0FF_EE01, 32'd0,         0, "b2b_wr_im");
    applyStimulus(1'b1, 32'h3000_00CC, 32'h1111_2222, 32'd0,         0, "wr_ob_illegal");
    applyStimulus(1'b0, 32'h3000_00C4, 32'd0,        32'h3333_4444,  0, "rd_ib_illegal");
    applyStimulus(1'b0, 32'h3000_0000, 32'd0,        32'h5555_6666,  0, "rd_unmapped");
    applyStimulus(1'b0, 32'h3000_0104, 32'd0,        32'h7777_8888,  2, "rd_sa_drop");
    applyStimulus(1'b1, 32'h3000_00C8, 32'h9999_AAAA, 32'd0,         0, "wr_wb_after_drop");
    applyStimulus(1'b0, 32'h3000_00CC, 32'd0,        32'hBBBB_CCCC,  3, "rd_ob_reset");
    applyStimulus(1'b1, 32'h4000_00C4, 32'hDDDD_EEEE, 32'd0,         0, "base_miss");
    applyStimulus(1'b0, 32'h3000_0104, 32'd0,        32'h0BAD_F00D,  0, "rd_sa");

    $display("[TB] random accesses");
    for (int i = 0; i < 40; i++) begin
      a = BASE | {22'd0, off_tbl[$urandom_range(0, 7)], 2'b00};
      if ($urandom_range(0, 99) < 15) a[31:24] = 8'h40 + 8'($urandom_range(0, 15));
      w = 1'($urandom);
      m = ($urandom_range(0, 2) == 0) ? 1 : 0;
      applyStimulus(w, a, $urandom, $urandom, m, $sformatf("rnd%0d", i));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // Absolute time guard so the run always ends
  initial begin
    #200000;
    $display("[TB] FAIL timeout got=running want=finished");
    $fatal(1, "[TB] timeout");
  end

endmodule
